// File: rtl/dpcm_pkg.sv
// rtl/dpcm_pkg.sv - shared types and sizes for the two-channel DPCM APB scheduler
package dpcm_pkg;

  localparam int NUM_CH   = 2;
  localparam int SAMPLE_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    PSETUP,
    PACCESS,
    SETUP,
    ACCESS,
    RESP
  } sched_state_t;

endpackage

// File: rtl/dpcm_rr_arb.sv
// rtl/dpcm_rr_arb.sv - two-input round-robin arbiter, pointer moves only on a contested grant
module dpcm_rr_arb
  import dpcm_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic [NUM_CH-1:0] req_i,
  output logic [NUM_CH-1:0] gnt_o
);

  logic rr_q;
  logic rr_d;

  // Single requester wins outright; on contention rr_q picks and then points at the loser
  always_comb begin
    gnt_o = '0;
    rr_d  = rr_q;
    case (req_i)
      2'b01: gnt_o = 2'b01;
      2'b10: gnt_o = 2'b10;
      2'b11: begin
        gnt_o = rr_q ? 2'b10 : 2'b01;
        rr_d  = ~rr_q;
      end
      default: gnt_o = '0;
    endcase
  end

  // Pointer advances only while the scheduler is able to accept a grant
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_q <= 1'b0;
    end else if (en_i) begin
      rr_q <= rr_d;
    end
  end

endmodule

// File: rtl/dpcm_apb_sched.sv
// rtl/dpcm_apb_sched.sv - APB master time-sharing one DPCM encoder between two sample channels
module dpcm_apb_sched
  import dpcm_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic                             pclk,
  input  logic                             preset,
  input  logic [NUM_CH-1:0]                req,
  input  logic [NUM_CH-1:0][SAMPLE_W-1:0]  req_data,
  output logic [NUM_CH-1:0]                req_ack,
  output logic [NUM_CH-1:0]                rsp_valid,
  output logic [SAMPLE_W-1:0]              rsp_data,
  output logic                             rsp_err,
  output logic                             psel,
  output logic                             penable,
  output logic                             pwrite,
  output logic [SAMPLE_W-1:0]              pwdata,
  input  logic [SAMPLE_W-1:0]              presult,
  input  logic                             pready,
  output logic                             busy
);

  localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  sched_state_t                       state_q;
  logic                               g_q;
  logic [SAMPLE_W-1:0]                sample_q;
  logic [NUM_CH-1:0][SAMPLE_W-1:0]    ctx_q;
  logic                               last_ch_q;
  logic                               primed_q;
  logic [CNT_W-1:0]                   cnt_q;
  logic                               psel_q;
  logic                               penable_q;
  logic                               pwrite_q;
  logic [SAMPLE_W-1:0]                pwdata_q;
  logic [NUM_CH-1:0]                  rsp_valid_q;
  logic [SAMPLE_W-1:0]                rsp_data_q;
  logic                               rsp_err_q;

  logic [NUM_CH-1:0]                  gnt;
  logic                               g_d;
  logic                               prime_d;
  logic                               timed_out;

  dpcm_rr_arb u_arb (
    .clk_i (pclk),
    .rst_i (preset),
    .en_i  (state_q == IDLE),
    .req_i (req),
    .gnt_o (gnt)
  );

  // Granted channel index and whether the slave predictor must be restored first
  always_comb begin
    g_d       = gnt[1];
    prime_d   = !primed_q || (g_d != last_ch_q);
    timed_out = (cnt_q == CNT_W'(TIMEOUT));
  end

  // Accept is a same-cycle pulse in IDLE; held off while reset is asserted
  assign req_ack   = ((state_q == IDLE) && !preset) ? gnt : '0;
  assign busy      = (state_q != IDLE);
  assign psel      = psel_q;
  assign penable   = penable_q;
  assign pwrite    = pwrite_q;
  assign pwdata    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;

  // Scheduler FSM: grant, optional priming write, sample write, one-cycle response
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_q     <= IDLE;
      g_q         <= 1'b0;
      sample_q    <= '0;
      ctx_q       <= '0;
      last_ch_q   <= 1'b0;
      primed_q    <= 1'b0;
      cnt_q       <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      pwrite_q    <= 1'b1;
      rsp_valid_q <= '0;
      case (state_q)
        IDLE: begin
          if (|gnt) begin
            g_q      <= g_d;
            sample_q <= req_data[g_d];
            psel_q   <= 1'b1;
            if (prime_d) begin
              pwdata_q <= ctx_q[g_d];
              state_q  <= PSETUP;
            end else begin
              pwdata_q <= req_data[g_d];
              state_q  <= SETUP;
            end
          end
        end
        PSETUP, SETUP: begin
          penable_q <= 1'b1;
          cnt_q     <= '0;
          state_q   <= (state_q == PSETUP) ? PACCESS : ACCESS;
        end
        PACCESS, ACCESS: begin
          if (pready) begin
            if (state_q == PACCESS) begin
              // Priming result is meaningless; only the predictor restore matters
              primed_q  <= 1'b1;
              last_ch_q <= g_q;
              penable_q <= 1'b0;
              pwdata_q  <= sample_q;
              state_q   <= SETUP;
            end else begin
              ctx_q[g_q]       <= sample_q;
              rsp_data_q       <= presult;
              rsp_err_q        <= 1'b0;
              rsp_valid_q[g_q] <= 1'b1;
              psel_q           <= 1'b0;
              penable_q        <= 1'b0;
              state_q          <= RESP;
            end
          end else if (timed_out) begin
            // Slave state is now unknown, so force a restore on the next transfer
            primed_q         <= 1'b0;
            rsp_data_q       <= '0;
            rsp_err_q        <= 1'b1;
            rsp_valid_q[g_q] <= 1'b1;
            psel_q           <= 1'b0;
            penable_q        <= 1'b0;
            state_q          <= RESP;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        RESP: begin
          rsp_data_q <= '0;
          rsp_err_q  <= 1'b0;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dpcm_apb_sched.sv
// tb/tb_dpcm_apb_sched.sv - self-checking bench for dpcm_apb_sched
module tb_dpcm_apb_sched;

  logic             pclk = 1'b0;
  logic             preset = 1'b1;
  logic [1:0]       req = '0;
  logic [1:0][7:0]  req_data = '0;
  logic [1:0]       req_ack;
  logic [1:0]       rsp_valid;
  logic [7:0]       rsp_data;
  logic             rsp_err;
  logic             psel;
  logic             penable;
  logic             pwrite;
  logic [7:0]       pwdata;
  logic [7:0]       presult;
  logic             pready;
  logic             busy;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  dpcm_apb_sched #(.TIMEOUT(15)) dut (
    .pclk      (pclk),
    .preset    (preset),
    .req       (req),
    .req_data  (req_data),
    .req_ack   (req_ack),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .psel      (psel),
    .penable   (penable),
    .pwrite    (pwrite),
    .pwdata    (pwdata),
    .presult   (presult),
    .pready    (pready),
    .busy      (busy)
  );

  always #5 pclk = ~pclk;
  always @(posedge pclk) cyc <= cyc + 1;

  // Behavioural DPCM slave: residual = sample - predictor, predictor loads on each completed write
  logic [7:0] pred = 8'h5A;
  int         acc_n = 0;
  int         waits_cfg = 0;
  logic       hold_low = 1'b0;

  assign pready  = !hold_low && (acc_n >= waits_cfg);
  assign presult = pwdata - pred;

  always @(posedge pclk) begin
    if (psel && penable && pready) pred <= pwdata;
    if (psel && penable && !pready) acc_n <= acc_n + 1;
    else acc_n <= 0;
  end

  typedef struct {
    int         ch;
    logic [7:0] data;
    int         cyc;
  } ack_t;

  typedef struct {
    int         ch;
    logic [7:0] data;
    logic       err;
    int         cyc;
  } rsp_t;

  typedef struct {
    logic       ok;
    int         ch;
    int         rch;
    logic [7:0] res;
    logic       err;
    int         lat;
    int         nwr;
    logic [7:0] w0;
    logic [7:0] w1;
    int         extra_ack;
    logic       gap_ok;
  } xres_t;

  typedef struct {
    int         ch;
    logic [7:0] data;
    int         waits;
    int         nwr;
    logic [7:0] w0;
    logic [7:0] w1;
    logic [7:0] res;
    int         lat;
  } vec_t;

  ack_t       ack_q[$];
  rsp_t       rsp_q[$];
  logic [7:0] wr_q[$];
  int         last_rsp_cyc = -1;

  // Reference state: per-channel last encoded sample, slave ownership, arbiter pointer
  logic [7:0] m_ctx [2];
  logic       m_primed;
  int         m_last;
  logic       m_rr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  task automatic model_reset();
    m_ctx[0] = 8'h00;
    m_ctx[1] = 8'h00;
    m_primed = 1'b0;
    m_last   = 0;
    m_rr     = 1'b0;
  endtask

  // Observer: protocol invariants plus capture of accepts, completed writes and responses
  always @(negedge pclk) begin
    if (!preset) begin
      if (psel) chk("pwrite_high", pwrite, 1);
      if (penable) chk("penable_needs_psel", psel, 1);
      if (psel && penable && pready) wr_q.push_back(pwdata);
      if (req_ack != 2'b00) begin
        chk("ack_onehot", $countones(req_ack), 1);
        chk("ack_requested", req_ack & ~req, 0);
        chk("ack_not_busy", busy, 0);
        ack_q.push_back('{ch: int'(req_ack[1]), data: req_data[req_ack[1]], cyc: cyc});
      end
      if (rsp_valid != 2'b00) begin
        chk("rsp_onehot", $countones(rsp_valid), 1);
        chk("rsp_apb_idle", {psel, penable}, 0);
        chk("rsp_busy", busy, 1);
        rsp_q.push_back('{ch: int'(rsp_valid[1]), data: rsp_data, err: rsp_err, cyc: cyc});
      end
    end
  end

  // Wait for one accept, release that request, then wait for its response
  task automatic wait_xfer(output xres_t r);
    ack_t a;
    rsp_t s;
    int   t;
    r = '{default: 0};
    t = 0;
    while (ack_q.size() == 0 && t < 100) begin step(); t++; end
    if (ack_q.size() == 0) return;
    a = ack_q.pop_front();
    req[a.ch] = 1'b0;
    wr_q.delete();
    r.ch = a.ch;
    r.gap_ok = (a.cyc > last_rsp_cyc);
    t = 0;
    while (rsp_q.size() == 0 && t < 100) begin step(); t++; end
    if (rsp_q.size() == 0) return;
    s = rsp_q.pop_front();
    last_rsp_cyc = s.cyc;
    r.rch = s.ch;
    r.res = s.data;
    r.err = s.err;
    r.lat = s.cyc - a.cyc;
    r.nwr = wr_q.size();
    if (r.nwr > 0) r.w0 = wr_q[0];
    if (r.nwr > 1) r.w1 = wr_q[1];
    r.extra_ack = ack_q.size();
    r.ok = 1'b1;
  endtask

  // Transfer-level expectation: restore needed unless the slave already owns this channel
  task automatic check_model(input xres_t r, input int exp_ch, input logic [7:0] exp_data, input int waits);
    logic       prime;
    logic [7:0] exp_res;
    chk("xfer_done", r.ok, 1);
    if (!r.ok) return;
    prime   = !m_primed || (exp_ch != m_last);
    exp_res = exp_data - m_ctx[exp_ch];
    chk("grant_ch", r.ch, exp_ch);
    chk("rsp_ch", r.rch, exp_ch);
    chk("no_ack_while_busy", r.extra_ack, 0);
    chk("accept_after_resp", r.gap_ok, 1);
    chk("rsp_err", r.err, 0);
    chk("residual", r.res, exp_res);
    chk("nwrites", r.nwr, prime ? 2 : 1);
    if (prime) begin
      chk("prime_data", r.w0, m_ctx[exp_ch]);
      chk("sample_data", r.w1, exp_data);
    end else begin
      chk("sample_data", r.w0, exp_data);
    end
    chk("latency", r.lat, 3 + waits + (prime ? 2 + waits : 0));
    m_ctx[exp_ch] = exp_data;
    m_primed      = 1'b1;
    m_last        = exp_ch;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       tbl [7];
    xres_t      r;
    int         t;
    int         exp_ch;
    logic [1:0] pending;
    logic       found;

    tbl[0] = '{0, 8'h10, 0, 2, 8'h00, 8'h10, 8'h10, 5};
    tbl[1] = '{1, 8'h7F, 0, 2, 8'h00, 8'h7F, 8'h7F, 5};
    tbl[2] = '{0, 8'h30, 0, 2, 8'h10, 8'h30, 8'h20, 5};
    tbl[3] = '{0, 8'h20, 0, 1, 8'h20, 8'h00, 8'hF0, 3};
    tbl[4] = '{0, 8'h25, 2, 1, 8'h25, 8'h00, 8'h05, 5};
    tbl[5] = '{1, 8'h80, 1, 2, 8'h7F, 8'h80, 8'h01, 7};
    tbl[6] = '{1, 8'h00, 0, 1, 8'h00, 8'h00, 8'h80, 3};

    model_reset();

    // Reset state, with a request present to show accept is suppressed
    req = 2'b01;
    step(); step();
    chk("reset_outputs", {psel, penable, pwrite, pwdata, req_ack, rsp_valid, rsp_data, rsp_err, busy}, 0);
    req = 2'b00;
    preset = 1'b0;
    step();
    chk("idle_after_reset", {busy, psel, penable}, 0);
    chk("pwrite_after_reset", pwrite, 1);

    // Directed vectors: priming, back-to-back, alternation, wait states
    for (int i = 0; i < 7; i++) begin
      waits_cfg = tbl[i].waits;
      req_data[tbl[i].ch] = tbl[i].data;
      req[tbl[i].ch] = 1'b1;
      wait_xfer(r);
      chk($sformatf("vec%0d_done", i), r.ok, 1);
      if (r.ok) begin
        chk($sformatf("vec%0d_ch", i), r.ch, tbl[i].ch);
        chk($sformatf("vec%0d_rsp_ch", i), r.rch, tbl[i].ch);
        chk($sformatf("vec%0d_err", i), r.err, 0);
        chk($sformatf("vec%0d_res", i), r.res, tbl[i].res);
        chk($sformatf("vec%0d_lat", i), r.lat, tbl[i].lat);
        chk($sformatf("vec%0d_nwr", i), r.nwr, tbl[i].nwr);
        chk($sformatf("vec%0d_w0", i), r.w0, tbl[i].w0);
        if (tbl[i].nwr == 2) chk($sformatf("vec%0d_w1", i), r.w1, tbl[i].w1);
        chk($sformatf("vec%0d_no_busy_ack", i), r.extra_ack, 0);
        chk($sformatf("vec%0d_gap", i), r.gap_ok, 1);
      end
      m_ctx[tbl[i].ch] = tbl[i].data;
      m_primed = 1'b1;
      m_last   = tbl[i].ch;
    end

    // Timeout on an already-primed channel: abort 16 cycles after ACCESS entry
    waits_cfg = 0;
    hold_low = 1'b1;
    req_data[1] = 8'h44;
    req[1] = 1'b1;
    wait_xfer(r);
    chk("to_done", r.ok, 1);
    if (r.ok) begin
      chk("to_ch", r.rch, 1);
      chk("to_err", r.err, 1);
      chk("to_data", r.res, 0);
      chk("to_lat", r.lat, 18);
      chk("to_nwr", r.nwr, 0);
    end
    m_primed = 1'b0;
    hold_low = 1'b0;
    req_data[1] = 8'h45;
    req[1] = 1'b1;
    wait_xfer(r);
    check_model(r, 1, 8'h45, 0);

    // Reset in the middle of ACCESS
    waits_cfg = 3;
    req_data[1] = 8'h66;
    req[1] = 1'b1;
    t = 0;
    while (ack_q.size() == 0 && t < 20) begin step(); t++; end
    chk("rst_ack_seen", ack_q.size() > 0, 1);
    if (ack_q.size() > 0) void'(ack_q.pop_front());
    found = 1'b0;
    t = 0;
    while (!found && t < 20) begin
      step();
      t++;
      found = psel && penable && (pwdata == 8'h66);
    end
    chk("rst_reached_access", found, 1);
    #2;
    preset = 1'b1;
    #1;
    chk("rst_async_outputs", {psel, penable, pwrite, pwdata, req_ack, rsp_valid, rsp_data, rsp_err, busy}, 0);
    step(); step();
    req = 2'b00;
    preset = 1'b0;
    model_reset();
    waits_cfg = 0;
    for (int i = 0; i < 20; i++) step();
    chk("rst_no_rsp", rsp_q.size(), 0);
    chk("rst_no_ack", ack_q.size(), 0);
    rsp_q.delete();
    ack_q.delete();
    req_data[1] = 8'h70;
    req[1] = 1'b1;
    wait_xfer(r);
    check_model(r, 1, 8'h70, 0);

    // Both requests held: grants alternate starting from channel 0
    req_data[0] = 8'h11;
    req_data[1] = 8'h22;
    req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      exp_ch = int'(m_rr);
      m_rr = ~m_rr;
      wait_xfer(r);
      check_model(r, exp_ch, req_data[exp_ch], 0);
      if (k < 3) begin
        req_data[exp_ch] = req_data[exp_ch] + 8'h13;
        req[exp_ch] = 1'b1;
      end
    end
    req = 2'b00;
    step();

    // Randomised traffic against the transfer-level model
    for (int it = 0; it < 40; it++) begin
      pending = 2'($urandom_range(1, 3));
      waits_cfg = $urandom_range(0, 2);
      req_data[0] = 8'($urandom);
      req_data[1] = 8'($urandom);
      req = pending;
      while (pending != 2'b00) begin
        if (pending == 2'b11) begin
          exp_ch = int'(m_rr);
          m_rr = ~m_rr;
        end else begin
          exp_ch = int'(pending[1]);
        end
        wait_xfer(r);
        check_model(r, exp_ch, req_data[exp_ch], waits_cfg);
        pending[exp_ch] = 1'b0;
      end
      req = 2'b00;
      if ($urandom_range(0, 1) == 1) step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
